// File: rtl/disp_pkg.sv
// Shared definitions for the display source controller: state encoding, default width,
// and a counter-width helper.
package disp_pkg;

    localparam int DISP_W = 8;

    typedef enum logic [1:0] {
        SHOW_TOP = 2'd0,
        ENTRY    = 2'd1,
        HOLD     = 2'd2,
        ERROR    = 2'd3
    } disp_state_t;

    // Width of a down/up counter that must hold values 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/disp_source_ctrl_blink_prescaler.sv
// Blink prescaler: counts BLINK_HALF cycles per half-period and toggles phase at each wrap.
// Held in restart (count 0, phase lit) while run is low.
module blink_prescaler
    import disp_pkg::*;
#(
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic phase
);

    localparam int CW = cnt_w(BLINK_HALF);

    logic [CW-1:0] r_cnt;
    logic          r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!run) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == CW'(BLINK_HALF - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/disp_source_ctrl.sv
// Display source controller: picks stack top / entry / held result / error for the decimal display.
// Define DISP_SRC_BLINK_EN to blink the display in ERROR; otherwise ERROR blanks it.
module disp_source_ctrl
    import disp_pkg::*;
#(
    parameter int W           = DISP_W,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BLINK_HALF  = 12_500_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] top_val,
    input  logic         top_valid,
    input  logic [W-1:0] entry_val,
    input  logic         entry_active,
    input  logic         result_strobe,
    input  logic         err_strobe,
    input  logic         clr_btn,
    input  logic         sign_btn,
    output logic [W-1:0] value,
    output logic         enable,
    output logic         non_signed,
    output logic [1:0]   state_dbg
);

    localparam int HW = cnt_w(HOLD_CYCLES);

    disp_state_t   r_state;
    logic [W-1:0]  r_value;
    logic [W-1:0]  r_hold_reg;
    logic [HW-1:0] r_hold_cnt;
    logic          r_enable;
    logic          r_non_signed;
    logic          r_clr_prev;
    logic          r_sign_prev;

    logic w_clr_rise;
    logic w_sign_rise;

    assign w_clr_rise  = clr_btn & ~r_clr_prev;
    assign w_sign_rise = sign_btn & ~r_sign_prev;

    // Outputs are computed alongside the next state so they match it one clock after sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SHOW_TOP;
            r_value      <= '0;
            r_hold_reg   <= '0;
            r_hold_cnt   <= '0;
            r_enable     <= 1'b0;
            r_non_signed <= 1'b0;
            r_clr_prev   <= 1'b0;
            r_sign_prev  <= 1'b0;
        end else begin
            r_clr_prev  <= clr_btn;
            r_sign_prev <= sign_btn;
            if (w_sign_rise)
                r_non_signed <= ~r_non_signed;

            if (err_strobe) begin
                r_state  <= ERROR;
                r_value  <= '0;
                r_enable <= 1'b0;
            end else if (r_state == ERROR) begin
                if (w_clr_rise) begin
                    r_state  <= SHOW_TOP;
                    r_value  <= top_val;
                    r_enable <= top_valid;
                end else begin
                    r_value  <= '0;
                    r_enable <= 1'b0;
                end
            end else if (result_strobe) begin
                r_state    <= HOLD;
                r_hold_reg <= top_val;
                r_hold_cnt <= HW'(HOLD_CYCLES - 1);
                r_value    <= top_val;
                r_enable   <= 1'b1;
            end else if (entry_active) begin
                r_state  <= ENTRY;
                r_value  <= entry_val;
                r_enable <= 1'b1;
            end else if (r_state == HOLD && r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
                r_value    <= r_hold_reg;
                r_enable   <= 1'b1;
            end else begin
                r_state  <= SHOW_TOP;
                r_value  <= top_val;
                r_enable <= top_valid;
            end
        end
    end

`ifdef DISP_SRC_BLINK_EN
    logic w_blink_run;
    logic w_phase;

    // A fresh error (including one coinciding with clear) restarts the blink lit.
    assign w_blink_run = (r_state == ERROR) && !err_strobe;

    blink_prescaler #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .run  (w_blink_run),
        .phase(w_phase)
    );

    assign enable = (r_state == ERROR) ? w_phase : r_enable;
`else
    assign enable = r_enable;
`endif

    assign value      = r_value;
    assign non_signed = r_non_signed;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_disp_source_ctrl.sv
// Self-checking bench for disp_source_ctrl (W=8, HOLD_CYCLES=4, BLINK_HALF=2) against a
// cycle-level behavioural model; honours DISP_SRC_BLINK_EN.
module tb_disp_source_ctrl;

    localparam int W  = 8;
    localparam int HC = 4;
    localparam int BH = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] top_val = '0;
    logic         top_valid = 1'b0;
    logic [W-1:0] entry_val = '0;
    logic         entry_active = 1'b0;
    logic         result_strobe = 1'b0;
    logic         err_strobe = 1'b0;
    logic         clr_btn = 1'b0;
    logic         sign_btn = 1'b0;
    logic [W-1:0] value;
    logic         enable;
    logic         non_signed;
    logic [1:0]   state_dbg;

    always #5 clk = ~clk;

    disp_source_ctrl #(
        .W(W), .HOLD_CYCLES(HC), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst(rst),
        .top_val(top_val), .top_valid(top_valid),
        .entry_val(entry_val), .entry_active(entry_active),
        .result_strobe(result_strobe), .err_strobe(err_strobe),
        .clr_btn(clr_btn), .sign_btn(sign_btn),
        .value(value), .enable(enable), .non_signed(non_signed), .state_dbg(state_dbg)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: mode 0=top,1=entry,2=hold,3=error
    int           m_mode;
    int           m_hold_left;
    int           m_err_age;
    logic [W-1:0] m_hold;
    logic [W-1:0] m_val;
    logic         m_en;
    logic         m_ns;
    logic         m_clr_last;
    logic         m_sign_last;

`ifdef DISP_SRC_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_hold_left = 0; m_err_age = 0; m_hold = '0;
        m_val = '0; m_en = 1'b0; m_ns = 1'b0; m_clr_last = 1'b0; m_sign_last = 1'b0;
    endtask

    task automatic model_step(input logic [W-1:0] tv, input logic tvld, input logic [W-1:0] ev,
                              input logic ea, input logic rs, input logic es,
                              input logic cb, input logic sb);
        bit clr_rise, sign_rise;
        clr_rise  = cb && !m_clr_last;
        sign_rise = sb && !m_sign_last;
        m_clr_last = cb; m_sign_last = sb;
        if (sign_rise) m_ns = !m_ns;
        if (es) begin
            m_mode = 3; m_err_age = 0;
        end else if (m_mode == 3) begin
            if (clr_rise) m_mode = 0;
            else m_err_age++;
        end else if (rs) begin
            m_mode = 2; m_hold = tv; m_hold_left = HC;
        end else if (ea) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_hold_left--;
            if (m_hold_left == 0) m_mode = 0;
        end else begin
            m_mode = 0;
        end
        case (m_mode)
            0: begin m_val = tv;     m_en = tvld; end
            1: begin m_val = ev;     m_en = 1'b1; end
            2: begin m_val = m_hold; m_en = 1'b1; end
            default: begin
                m_val = '0;
                m_en  = BLINK ? (((m_err_age / BH) % 2) == 0) : 1'b0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, "_value"}, value, m_val);
        check({tag, "_enable"}, W'(enable), W'(m_en));
        check({tag, "_nonsigned"}, W'(non_signed), W'(m_ns));
        check({tag, "_state"}, W'(state_dbg), W'(m_mode));
    endtask

    task automatic tick(input string tag);
        logic [W-1:0] tv, ev;
        logic tvld, ea, rs, es, cb, sb;
        tv = top_val; tvld = top_valid; ev = entry_val; ea = entry_active;
        rs = result_strobe; es = err_strobe; cb = clr_btn; sb = sign_btn;
        @(posedge clk);
        model_step(tv, tvld, ev, ea, rs, es, cb, sb);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic exp_blink [6];
        exp_blink = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst = 1'b0;

        // Result freezes for HC cycles while the stack top moves on
        top_val = 8'hF6; top_valid = 1'b1; result_strobe = 1'b1;
        tick("res0");
        check("res_value_F6", value, 8'hF6);
        result_strobe = 1'b0; top_val = 8'h05;
        for (int i = 1; i < HC; i++) tick($sformatf("hold%0d", i));
        check("hold_last_F6", value, 8'hF6);
        tick("hold_exit");
        check("hold_exit_05", value, 8'h05);
        check("hold_exit_state", W'(state_dbg), 8'd0);

        // Entry abandons hold immediately
        result_strobe = 1'b1; tick("res1");
        result_strobe = 1'b0; entry_active = 1'b1; entry_val = 8'd42;
        tick("entry");
        check("entry_state", W'(state_dbg), 8'd1);
        check("entry_value", value, 8'd42);
        entry_active = 1'b0; tick("entry_drop");

        // Error wins over a coincident result; blink pattern
        err_strobe = 1'b1; result_strobe = 1'b1; top_val = 8'h77;
        tick("err0");
        check("err_state", W'(state_dbg), 8'd3);
        check("err_pat0", W'(enable), W'(BLINK & exp_blink[0]));
        err_strobe = 1'b0; result_strobe = 1'b0; entry_active = 1'b1;
        for (int i = 1; i < 6; i++) begin
            tick($sformatf("blink%0d", i));
            check($sformatf("err_pat%0d", i), W'(enable), W'(BLINK & exp_blink[i]));
        end
        entry_active = 1'b0;

        // Held sign button toggles once, even in ERROR
        sign_btn = 1'b1;
        for (int i = 0; i < 10; i++) tick($sformatf("sign_hold%0d", i));
        check("sign_once", W'(non_signed), 8'd1);
        sign_btn = 1'b0; tick("sign_rel");
        sign_btn = 1'b1; tick("sign_press2");
        check("sign_back", W'(non_signed), 8'd0);
        sign_btn = 1'b0;

        // Clear coincident with a fresh error keeps ERROR, then a clean clear exits
        clr_btn = 1'b1; err_strobe = 1'b1; tick("clr_err");
        check("clr_err_state", W'(state_dbg), 8'd3);
        clr_btn = 1'b0; err_strobe = 1'b0; tick("clr_low");
        clr_btn = 1'b1; tick("clr_rise");
        check("clr_state", W'(state_dbg), 8'd0);
        clr_btn = 1'b0;

        // Empty stack blanks; a result still shows
        top_valid = 1'b0; top_val = 8'h12; tick("empty");
        check("empty_enable", W'(enable), 8'd0);
        top_val = 8'h33; result_strobe = 1'b1; tick("empty_res");
        check("empty_res_enable", W'(enable), 8'd1);
        check("empty_res_value", value, 8'h33);
        result_strobe = 1'b0; tick("hold_mid");

        // Asynchronous reset mid-HOLD
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        #3 rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            top_val       = W'($urandom);
            top_valid     = ($urandom_range(0, 9) != 0);
            entry_val     = W'($urandom);
            if ($urandom_range(0, 6) == 0) entry_active = ~entry_active;
            result_strobe = ($urandom_range(0, 11) == 0);
            err_strobe    = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) clr_btn = ~clr_btn;
            if ($urandom_range(0, 7) == 0) sign_btn = ~sign_btn;
            tick($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
